// File: rtl/mult_hilo_ctrl.sv
// mult_hilo_ctrl: sequences the 16x16 shift-add multiplier for the execute stage.
// It latches the operands, issues the start pulse and collects the product into HI/LO.
// It serves MF/MT HI/LO accesses and stalls the pipeline while a multiply is in flight.
module mult_hilo_ctrl #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 8
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Mul_Req,
    input  logic [15:0] Mul_A,
    input  logic [15:0] Mul_B,
    input  logic        Mf_Req,
    input  logic        Mf_Sel,
    input  logic        Mt_Req,
    input  logic        Mt_Sel,
    input  logic [15:0] Mt_Data,
    output logic [15:0] Mf_Data,
    output logic        Stall,
    output logic        Busy,
    output logic        Err,
    output logic [15:0] Hi,
    output logic [15:0] Lo,
    output logic        Mult_St,
    output logic [15:0] Mult_A,
    output logic [15:0] Mult_B,
    input  logic        Mult_Idle,
    input  logic        Mult_Done,
    input  logic [31:0] Mult_Prod
);

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;

    logic               accept;
    logic               mt_wr;
    logic               run_done;
    logic               run_tmo;
    logic               start_go;

    // A multiply is taken whenever the controller is idle; a simultaneous MT is
    // the one that gets held, so it lands after the product and overwrites it.
    assign accept   = (state == IDLE) & Mul_Req;
    assign mt_wr    = Mt_Req & ~Stall;
    // The multiplier has no reset, so start waits until it reports idle.
    assign start_go = (state == START) & Mult_Idle;
    // Done wins over timeout when both happen in the same cycle.
    assign run_done = (state == RUN) & Mult_Done;
    assign run_tmo  = (state == RUN) & ~Mult_Done & (cnt == CNT_W'(TIMEOUT - 1));

    // Reads see the current HI/LO, so an MF alongside an accepted multiply gets the old value.
    assign Mf_Data = Mf_Sel ? Hi : Lo;

    // State register.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> START on accept, START -> RUN once started, RUN -> IDLE on done/timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (start_go) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (run_done || run_tmo) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode: start pulse, busy flag and pipeline stall.
    always_comb begin
        Mult_St = 1'b0;
        Busy    = (state != IDLE);
        Stall   = (Busy & (Mul_Req | Mf_Req | Mt_Req)) | (~Busy & Mul_Req & Mt_Req);
        if (state == START) begin
            Mult_St = Mult_Idle;
        end
    end

    // Timeout counter: cleared on the start cycle, counts every cycle spent in RUN.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            cnt <= '0;
        end else if (start_go) begin
            cnt <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Operand registers: captured on accept and held while the multiplier consumes them.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Mult_A <= '0;
            Mult_B <= '0;
        end else if (accept) begin
            Mult_A <= Mul_A;
            Mult_B <= Mul_B;
        end
    end

    // HI/LO: product load from RUN, otherwise unstalled MT writes to the selected half.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Hi <= '0;
            Lo <= '0;
        end else if (run_done) begin
            Hi <= Mult_Prod[2*DATA_W-1:DATA_W];
            Lo <= Mult_Prod[DATA_W-1:0];
        end else if (mt_wr) begin
            if (Mt_Sel) begin
                Hi <= Mt_Data;
            end else begin
                Lo <= Mt_Data;
            end
        end
    end

    // Sticky timeout flag; only reset clears it and it does not block new multiplies.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Err <= 1'b0;
        end else if (run_tmo) begin
            Err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// tb_mult_hilo_ctrl: directed bench for mult_hilo_ctrl with a behavioural
// fixed-latency multiplier model and hand-computed expected values.
module tb_mult_hilo_ctrl;

    localparam int TIMEOUT = 40;
    localparam int CNT_W   = 8;
    localparam int LAT     = 33;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Mul_Req;
    logic [15:0] Mul_A;
    logic [15:0] Mul_B;
    logic        Mf_Req;
    logic        Mf_Sel;
    logic        Mt_Req;
    logic        Mt_Sel;
    logic [15:0] Mt_Data;
    logic [15:0] Mf_Data;
    logic        Stall;
    logic        Busy;
    logic        Err;
    logic [15:0] Hi;
    logic [15:0] Lo;
    logic        Mult_St;
    logic [15:0] Mult_A;
    logic [15:0] Mult_B;
    logic        Mult_Idle;
    logic        Mult_Done;
    logic [31:0] Mult_Prod;

    // Multiplier model state and bench overrides.
    logic        m_busy = 1'b0;
    logic [7:0]  m_cnt  = 8'd0;
    logic [31:0] m_prod = 32'd0;
    logic        m_done = 1'b0;
    logic        suppress_done  = 1'b0;
    logic        force_idle_low = 1'b0;
    logic        force_done     = 1'b0;
    logic [31:0] force_prod     = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    mult_hilo_ctrl #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Mul_Req  (Mul_Req),
        .Mul_A    (Mul_A),
        .Mul_B    (Mul_B),
        .Mf_Req   (Mf_Req),
        .Mf_Sel   (Mf_Sel),
        .Mt_Req   (Mt_Req),
        .Mt_Sel   (Mt_Sel),
        .Mt_Data  (Mt_Data),
        .Mf_Data  (Mf_Data),
        .Stall    (Stall),
        .Busy     (Busy),
        .Err      (Err),
        .Hi       (Hi),
        .Lo       (Lo),
        .Mult_St  (Mult_St),
        .Mult_A   (Mult_A),
        .Mult_B   (Mult_B),
        .Mult_Idle(Mult_Idle),
        .Mult_Done(Mult_Done),
        .Mult_Prod(Mult_Prod)
    );

    assign Mult_Idle = ~m_busy & ~force_idle_low;
    assign Mult_Done = (m_done & ~suppress_done) | force_done;
    assign Mult_Prod = force_done ? force_prod : m_prod;

    // Fixed-latency multiplier: starts on Mult_St when idle, pulses done after LAT-1 further edges.
    always @(posedge Clk) begin
        m_done <= 1'b0;
        if (Mult_St && !m_busy) begin
            m_busy <= 1'b1;
            m_cnt  <= 8'd1;
            m_prod <= {16'd0, Mult_A} * {16'd0, Mult_B};
        end else if (m_busy) begin
            if (m_cnt == 8'(LAT - 1)) begin
                m_done <= 1'b1;
                m_busy <= 1'b0;
            end
            m_cnt <= m_cnt + 8'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Sample once per cycle until Busy drops; reports busy samples, start pulses and stall gaps.
    task automatic wait_idle(input int bound, output int n, output int st, output int gaps);
        n = 0;
        st = 0;
        gaps = 0;
        while (Busy === 1'b1 && n < bound) begin
            if (Mult_St) st++;
            if (!Stall) gaps++;
            n++;
            step();
        end
    endtask

    int n, st, gaps;

    initial begin
        Rst_n   = 1'b0;
        Mul_Req = 1'b0;
        Mul_A   = 16'd0;
        Mul_B   = 16'd0;
        Mf_Req  = 1'b0;
        Mf_Sel  = 1'b0;
        Mt_Req  = 1'b0;
        Mt_Sel  = 1'b0;
        Mt_Data = 16'd0;
        step();
        step();

        // Reset state
        check("rst_hi", Hi, 0);
        check("rst_lo", Lo, 0);
        check("rst_err", Err, 0);
        check("rst_busy", Busy, 0);
        check("rst_stall", Stall, 0);
        check("rst_st", Mult_St, 0);
        check("rst_opa", Mult_A, 0);
        Rst_n = 1'b1;
        step();

        // Basic multiply 3*5
        Mul_A = 16'd3; Mul_B = 16'd5; Mul_Req = 1'b1;
        #1;
        check("t1_acc_stall", Stall, 0);
        step();
        Mul_Req = 1'b0;
        #1;
        check("t1_busy", Busy, 1);
        check("t1_opa", Mult_A, 16'd3);
        check("t1_opb", Mult_B, 16'd5);
        wait_idle(200, n, st, gaps);
        check("t1_wait", Busy, 0);
        check("t1_busy_cycles", n, 34);
        check("t1_st_pulses", st, 1);
        check("t1_lo", Lo, 16'h000F);
        check("t1_hi", Hi, 16'h0000);
        check("t1_err", Err, 0);

        // Max operands
        Mul_A = 16'hFFFF; Mul_B = 16'hFFFF; Mul_Req = 1'b1;
        step();
        Mul_Req = 1'b0;
        #1;
        wait_idle(200, n, st, gaps);
        check("t2_wait", Busy, 0);
        check("t2_hi", Hi, 16'hFFFE);
        check("t2_lo", Lo, 16'h0001);

        // Read-after-multiply hazard
        Mul_A = 16'h1234; Mul_B = 16'h0100; Mul_Req = 1'b1;
        step();
        Mul_Req = 1'b0; Mf_Req = 1'b1; Mf_Sel = 1'b1;
        #1;
        check("t3_stall", Stall, 1);
        wait_idle(200, n, st, gaps);
        check("t3_wait", Busy, 0);
        check("t3_stall_gaps", gaps, 0);
        check("t3_stall_after", Stall, 0);
        check("t3_mf_hi", Mf_Data, 16'h0012);
        Mf_Sel = 1'b0;
        #1;
        check("t3_mf_lo", Mf_Data, 16'h3400);
        Mf_Req = 1'b0;
        step();

        // Timeout, with an MF in the accept cycle returning the old HI
        suppress_done = 1'b1;
        Mul_A = 16'd3; Mul_B = 16'd3; Mul_Req = 1'b1; Mf_Req = 1'b1; Mf_Sel = 1'b1;
        #1;
        check("t4_mf_stall", Stall, 0);
        check("t4_mf_pre", Mf_Data, 16'h0012);
        step();
        Mul_Req = 1'b0; Mf_Req = 1'b0;
        #1;
        wait_idle(200, n, st, gaps);
        check("t4_wait", Busy, 0);
        check("t4_busy_cycles", n, 41);
        check("t4_st_pulses", st, 1);
        check("t4_err", Err, 1);
        check("t4_hi", Hi, 16'h0012);
        check("t4_lo", Lo, 16'h3400);
        force_prod = 32'hDEADBEEF; force_done = 1'b1;
        step();
        force_done = 1'b0;
        #1;
        check("t4_late_hi", Hi, 16'h0012);
        check("t4_late_lo", Lo, 16'h3400);
        check("t4_late_busy", Busy, 0);
        suppress_done = 1'b0;
        step();

        // Mul 2*2 together with MT LO=AAAA
        Mul_A = 16'd2; Mul_B = 16'd2; Mul_Req = 1'b1;
        Mt_Req = 1'b1; Mt_Sel = 1'b0; Mt_Data = 16'hAAAA;
        #1;
        check("t5_stall_idle", Stall, 1);
        step();
        Mul_Req = 1'b0;
        #1;
        check("t5_busy", Busy, 1);
        check("t5_lo_held", Lo, 16'h3400);
        wait_idle(200, n, st, gaps);
        check("t5_wait", Busy, 0);
        check("t5_stall_gaps", gaps, 0);
        check("t5_lo_prod", Lo, 16'h0004);
        check("t5_hi_prod", Hi, 16'h0000);
        check("t5_stall_after", Stall, 0);
        step();
        Mt_Req = 1'b0;
        #1;
        check("t5_lo_mt", Lo, 16'hAAAA);
        check("t5_hi_mt", Hi, 16'h0000);
        check("t5_err_sticky", Err, 1);
        step();

        // Reset mid-RUN, multiplier reported busy afterwards
        Mul_A = 16'h1111; Mul_B = 16'h2222; Mul_Req = 1'b1;
        step();
        Mul_Req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("t6_busy_pre", Busy, 1);
        Rst_n = 1'b0; force_idle_low = 1'b1;
        step();
        Rst_n = 1'b1;
        #1;
        check("t6_rst_hi", Hi, 0);
        check("t6_rst_lo", Lo, 0);
        check("t6_rst_err", Err, 0);
        check("t6_rst_busy", Busy, 0);
        Mul_A = 16'd7; Mul_B = 16'd6; Mul_Req = 1'b1;
        step();
        Mul_Req = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("t6_st_withheld", Mult_St, 0);
            check("t6_start_busy", Busy, 1);
            step();
        end
        force_idle_low = 1'b0;
        #1;
        wait_idle(300, n, st, gaps);
        check("t6_wait", Busy, 0);
        check("t6_st_pulses", st, 1);
        check("t6_lo", Lo, 16'h002A);
        check("t6_hi", Hi, 16'h0000);
        check("t6_err", Err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
